// File: rtl/ctrl_tx_pkg.sv
// Shared types and constants for the controller LED/buzzer transmit path.
// Build option: CTRL_TX_REFRESH_EN enables periodic resend of last_word.
package ctrl_tx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } ctrl_tx_state_t;

  localparam int CTRL_TX_FRAME_BITS  = 16;
  localparam int CTRL_TX_PLAYERS     = 4;
  localparam int CTRL_TX_PLAYER_BITS = 4;

  // Player n owns feedback bits [4n+3:4n].
  function automatic int player_lsb(input int n);
    return n * CTRL_TX_PLAYER_BITS;
  endfunction

  function automatic int player_msb(input int n);
    return n * CTRL_TX_PLAYER_BITS + CTRL_TX_PLAYER_BITS - 1;
  endfunction

endpackage

// File: rtl/ctrl_led_tx_phase.sv
// Half-bit phase timer: phase_end ticks on the last of CLK_DIV cycles.
// restart holds the count at zero so each new phase starts aligned.
module ctrl_tx_phase #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic phase_end
);

  logic [7:0] cnt;

  assign phase_end = !restart && (cnt == 8'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || phase_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/ctrl_led_tx.sv
// Serial transmitter for controller LED/buzzer words (595-style frame).
// Build option: CTRL_TX_REFRESH_EN resends last_word after REFRESH_CYCLES idle.
module ctrl_led_tx
  import ctrl_tx_pkg::*;
#(
  parameter int CLK_DIV        = 4,
  parameter int NUM_BITS       = CTRL_TX_FRAME_BITS,
  parameter int REFRESH_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [NUM_BITS-1:0] wr_data,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] last_word,
  output logic                sclk,
  output logic                sdata,
  output logic                latch
);

  localparam int BW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  ctrl_tx_state_t      state, state_n;
  logic [NUM_BITS-1:0] shreg, shreg_n;
  logic [NUM_BITS-1:0] word, word_n;
  logic [NUM_BITS-1:0] pend, pend_n;
  logic                pend_valid, pend_valid_n;
  logic [BW-1:0]       bit_cnt, bit_cnt_n;
  logic                phase_end;
  logic                frame_end;
  logic                load;
  logic [NUM_BITS-1:0] load_word;
  logic                refresh;

  ctrl_tx_phase #(
    .CLK_DIV (CLK_DIV)
  ) u_phase (
    .clk       (clk),
    .rst       (rst),
    .restart   (state == IDLE),
    .phase_end (phase_end)
  );

`ifdef CTRL_TX_REFRESH_EN
  localparam int RW = $clog2(REFRESH_CYCLES) + 1;

  logic [RW-1:0] idle_cnt;

  assign refresh = (state == IDLE) &&
                   (idle_cnt == RW'(REFRESH_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if (state != IDLE || wr_en || refresh) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign refresh = 1'b0;
`endif

  always_comb begin
    state_n      = state;
    shreg_n      = shreg;
    word_n       = word;
    pend_n       = pend;
    pend_valid_n = pend_valid;
    bit_cnt_n    = bit_cnt;
    frame_end    = 1'b0;
    load         = 1'b0;
    load_word    = '0;

    unique case (state)
      IDLE: begin
        if (wr_en || refresh) begin
          load      = 1'b1;
          load_word = wr_en ? wr_data : last_word;
        end
      end
      SHIFT_LO: begin
        if (phase_end) state_n = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (phase_end) begin
          if (bit_cnt == '0) begin
            state_n = LATCH;
          end else begin
            shreg_n   = shreg << 1;
            bit_cnt_n = bit_cnt - 1'b1;
            state_n   = SHIFT_LO;
          end
        end
      end
      LATCH: begin
        if (phase_end) begin
          frame_end = 1'b1;
          // A store landing on the final cycle beats an older pending word.
          if (wr_en) begin
            load         = 1'b1;
            load_word    = wr_data;
            pend_valid_n = 1'b0;
          end else if (pend_valid) begin
            load         = 1'b1;
            load_word    = pend;
            pend_valid_n = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (wr_en && state != IDLE && !frame_end) begin
      pend_n       = wr_data;
      pend_valid_n = 1'b1;
    end

    if (load) begin
      shreg_n   = load_word;
      word_n    = load_word;
      bit_cnt_n = BW'(NUM_BITS - 1);
      state_n   = SHIFT_LO;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      word       <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      bit_cnt    <= '0;
      sclk       <= 1'b0;
      sdata      <= 1'b0;
      latch      <= 1'b0;
      done       <= 1'b0;
      last_word  <= '0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      word       <= word_n;
      pend       <= pend_n;
      pend_valid <= pend_valid_n;
      bit_cnt    <= bit_cnt_n;
      sclk       <= (state_n == SHIFT_HI);
      latch      <= (state_n == LATCH);
      sdata      <= (state_n == SHIFT_LO || state_n == SHIFT_HI) ?
                    shreg_n[NUM_BITS-1] : 1'b0;
      done       <= frame_end;
      if (frame_end) last_word <= word;
    end
  end

  assign busy = (state != IDLE) | pend_valid;

endmodule
